// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared constants for the write-arbitrated FIFO controller: default data and
//   address widths, and the grant encoding used by the arbiter and the
//   controller's write-data mux.
package fifo_pkg;

  localparam int FIFO_DATASIZE = 8;
  localparam int FIFO_ADDRSIZE = 4;

  typedef logic grant_t;

  localparam grant_t GRANT_WR0 = 1'b0;
  localparam grant_t GRANT_WR1 = 1'b1;

  // Round-robin choice between two requesters: a lone requester wins, a tie
  // goes to whichever port did not win last time.
  function automatic grant_t rr_pick(input logic req0, input logic req1,
                                     input grant_t last_grant);
    grant_t pick;
    pick = GRANT_WR0;
    if (req0 && req1) begin
      pick = (last_grant == GRANT_WR0) ? GRANT_WR1 : GRANT_WR0;
    end else if (req1) begin
      pick = GRANT_WR1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_arbiter2.sv
// rr_arbiter2
//   Two-input round-robin arbiter with its own last-grant register.
//   Ports:
//     clk, rst_n      - clock, async active-low reset
//     en              - grants permitted this cycle
//     req0, req1      - requests
//     gnt0, gnt1      - one-hot grant (combinational)
//     gnt_any         - a grant is issued this cycle
//     gnt_sel         - index of the granted requester (GRANT_WR0/GRANT_WR1)
module rr_arbiter2
  import fifo_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  logic   req0,
  input  logic   req1,
  output logic   gnt0,
  output logic   gnt1,
  output logic   gnt_any,
  output grant_t gnt_sel
);

  grant_t last_grant_q;
  grant_t last_grant_d;

  always_comb begin
    gnt_sel      = rr_pick(req0, req1, last_grant_q);
    gnt_any      = en && (req0 || req1);
    gnt0         = gnt_any && (gnt_sel == GRANT_WR0);
    gnt1         = gnt_any && (gnt_sel == GRANT_WR1);
    last_grant_d = last_grant_q;
    if (gnt_any) begin
      last_grant_d = gnt_sel;
    end
  end

  // Reset to WR1 so that requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GRANT_WR1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Pointer/status controller for a shared fall-through fifomem with two
//   round-robin write requesters and one reader. The memory array lives in
//   the parent; this block drives its write port and read address.
//   Ports:
//     clk, rst_n                     - clock, async active-low reset
//     wr0_valid/wr0_data/wr0_ready   - write requester 0
//     wr1_valid/wr1_data/wr1_ready   - write requester 1
//     rd_valid/rd_ready/rd_data      - read side (rd_data = mem_rdata)
//     flush                          - synchronous clear of contents
//     full, empty, almost_full,count - occupancy status from registered pointers
//     overflow                       - sticky: a write was presented while full
//     mem_*                          - connections to fifomem
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int DATASIZE    = FIFO_DATASIZE,
  parameter int ADDRSIZE    = FIFO_ADDRSIZE,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr0_valid,
  input  logic [DATASIZE-1:0] wr0_data,
  output logic                wr0_ready,
  input  logic                wr1_valid,
  input  logic [DATASIZE-1:0] wr1_data,
  output logic                wr1_ready,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATASIZE-1:0] rd_data,
  input  logic                flush,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                mem_wclken,
  output logic [ADDRSIZE-1:0] mem_waddr,
  output logic [DATASIZE-1:0] mem_wdata,
  output logic                mem_wfull,
  output logic [ADDRSIZE-1:0] mem_raddr,
  input  logic [DATASIZE-1:0] mem_rdata
);

  localparam logic [ADDRSIZE:0] PTR_ONE   = {{ADDRSIZE{1'b0}}, 1'b1};
  localparam logic [ADDRSIZE:0] PTR_ZERO  = '0;
  localparam logic [ADDRSIZE:0] AFULL_CNT = AFULL_LEVEL[ADDRSIZE:0];

  logic [ADDRSIZE:0] wptr_q, wptr_d;
  logic [ADDRSIZE:0] rptr_q, rptr_d;
  logic              overflow_q, overflow_d;

  logic   wr_en;
  logic   gnt_any;
  grant_t gnt_sel;
  logic   rd_fire;

  // Status depends on registered pointers only, so a same-cycle read cannot
  // open space for a write while full.
  always_comb begin
    count       = wptr_q - rptr_q;
    empty       = (wptr_q == rptr_q);
    full        = (wptr_q[ADDRSIZE] != rptr_q[ADDRSIZE]) &&
                  (wptr_q[ADDRSIZE-1:0] == rptr_q[ADDRSIZE-1:0]);
    almost_full = (count >= AFULL_CNT);
    overflow    = overflow_q;
  end

  assign wr_en = !full && !flush;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (wr_en),
    .req0    (wr0_valid),
    .req1    (wr1_valid),
    .gnt0    (wr0_ready),
    .gnt1    (wr1_ready),
    .gnt_any (gnt_any),
    .gnt_sel (gnt_sel)
  );

  always_comb begin
    mem_wclken = gnt_any;
    mem_waddr  = wptr_q[ADDRSIZE-1:0];
    mem_wdata  = (gnt_sel == GRANT_WR1) ? wr1_data : wr0_data;
    mem_wfull  = full;
    mem_raddr  = rptr_q[ADDRSIZE-1:0];
  end

  // Fall-through memory: head word is visible combinationally.
  always_comb begin
    rd_valid = !empty && !flush;
    rd_data  = mem_rdata;
    rd_fire  = rd_valid && rd_ready;
  end

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    overflow_d = overflow_q;
    if (flush) begin
      wptr_d     = PTR_ZERO;
      rptr_d     = PTR_ZERO;
      overflow_d = 1'b0;
    end else begin
      if (gnt_any) begin
        wptr_d = wptr_q + PTR_ONE;
      end
      if (rd_fire) begin
        rptr_d = rptr_q + PTR_ONE;
      end
      if (full && (wr0_valid || wr1_valid)) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= PTR_ZERO;
      rptr_q     <= PTR_ZERO;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a behavioural fall-through fifomem.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr0_valid, wr1_valid, rd_ready, flush;
  logic [DW-1:0] wr0_data, wr1_data;
  logic          wr0_ready, wr1_ready, rd_valid;
  logic [DW-1:0] rd_data;
  logic          full, empty, almost_full, overflow;
  logic [AW:0]   count;
  logic          mem_wclken, mem_wfull;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wclken && !mem_wfull) mem[mem_waddr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_raddr];

  fifo_wr_arbiter #(.DATASIZE(DW), .ADDRSIZE(AW), .AFULL_LEVEL(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr0_valid   (wr0_valid),
    .wr0_data    (wr0_data),
    .wr0_ready   (wr0_ready),
    .wr1_valid   (wr1_valid),
    .wr1_data    (wr1_data),
    .wr1_ready   (wr1_ready),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .flush       (flush),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .mem_wclken  (mem_wclken),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .mem_wfull   (mem_wfull),
    .mem_raddr   (mem_raddr),
    .mem_rdata   (mem_rdata)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic push(input int port, input logic [DW-1:0] d);
    if (port == 0) begin
      wr0_valid = 1'b1; wr0_data = d;
    end else begin
      wr1_valid = 1'b1; wr1_data = d;
    end
    #1;
    chk("push_ready", int'(port == 0 ? wr0_ready : wr1_ready), 1);
    cyc();
    wr0_valid = 1'b0;
    wr1_valid = 1'b0;
  endtask

  task automatic pop(input logic [DW-1:0] exp);
    chk("pop_valid", int'(rd_valid), 1);
    chk("pop_data", int'(rd_data), int'(exp));
    rd_ready = 1'b1;
    cyc();
    rd_ready = 1'b0;
  endtask

  initial begin
    int n0, n1;
    wr0_valid = 0; wr1_valid = 0; rd_ready = 0; flush = 0;
    wr0_data = '0; wr1_data = '0;
    do_reset();
    #1;
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_afull", int'(almost_full), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_rdv", int'(rd_valid), 0);
    chk("rst_rdy0", int'(wr0_ready), 0);
    chk("rst_rdy1", int'(wr1_ready), 0);
    chk("rst_wclken", int'(mem_wclken), 0);

    // 1: basic push/pop
    push(0, 8'h11);
    chk("t1_rdv_same_cycle_empty", int'(rd_valid), 1);
    push(0, 8'h22);
    chk("t1_count", int'(count), 2);
    pop(8'h11);
    pop(8'h22);
    chk("t1_empty", int'(empty), 1);

    // 2: alternating grants with both valid, starting from reset tie-break
    do_reset();
    n0 = 0; n1 = 0;
    wr0_valid = 1; wr1_valid = 1;
    for (int i = 0; i < 4; i++) begin
      wr0_data = 8'(8'hA0 + n0);
      wr1_data = 8'(8'hB0 + n1);
      #1;
      chk("t2_gnt0", int'(wr0_ready), (i % 2 == 0) ? 1 : 0);
      chk("t2_gnt1", int'(wr1_ready), (i % 2 == 1) ? 1 : 0);
      cyc();
      if (i % 2 == 0) n0++; else n1++;
    end
    wr0_valid = 0; wr1_valid = 0;
    pop(8'hA0); pop(8'hB0); pop(8'hA1); pop(8'hB1);
    chk("t2_empty", int'(empty), 1);

    // 3: fill to full, almost_full threshold, refused 17th write
    for (int i = 0; i < 16; i++) begin
      push(0, 8'(8'h40 + i));
      chk("t3_count", int'(count), i + 1);
      chk("t3_afull", int'(almost_full), (i + 1 >= 12) ? 1 : 0);
      chk("t3_full", int'(full), (i + 1 == 16) ? 1 : 0);
    end
    wr0_valid = 1; wr0_data = 8'hEE;
    #1;
    chk("t3_refuse_rdy", int'(wr0_ready), 0);
    chk("t3_refuse_wclken", int'(mem_wclken), 0);
    cyc();
    chk("t3_ovf", int'(overflow), 1);
    chk("t3_count_hold", int'(count), 16);
    chk("t3_head", int'(rd_data), 8'h40);

    // 4: full with simultaneous write+read: write refused, read taken
    rd_ready = 1;
    #1;
    chk("t4_rdy_full", int'(wr0_ready), 0);
    chk("t4_rdv", int'(rd_valid), 1);
    chk("t4_head", int'(rd_data), 8'h40);
    cyc();
    rd_ready = 0;
    chk("t4_count15", int'(count), 15);
    #1;
    chk("t4_rdy_after", int'(wr0_ready), 1);
    cyc();
    wr0_valid = 0;
    chk("t4_count16", int'(count), 16);
    for (int i = 1; i < 16; i++) pop(8'(8'h40 + i));
    pop(8'hEE);
    chk("t4_empty", int'(empty), 1);

    // 5: pointer wrap with single write/read pairs
    for (int i = 0; i < 40; i++) begin
      push(1, 8'(i * 3 + 1));
      chk("t5_count", int'(count), 1);
      chk("t5_full", int'(full), 0);
      pop(8'(i * 3 + 1));
    end
    chk("t5_empty", int'(empty), 1);
    chk("t5_ovf_sticky", int'(overflow), 1);

    // 6: flush with contents and overflow set
    for (int i = 0; i < 5; i++) push(0, 8'(8'h60 + i));
    chk("t6_count5", int'(count), 5);
    flush = 1; wr0_valid = 1; wr0_data = 8'h77; rd_ready = 1;
    #1;
    chk("t6_flush_rdy", int'(wr0_ready), 0);
    chk("t6_flush_rdv", int'(rd_valid), 0);
    chk("t6_flush_wclken", int'(mem_wclken), 0);
    cyc();
    flush = 0; wr0_valid = 0; rd_ready = 0;
    chk("t6_empty", int'(empty), 1);
    chk("t6_count", int'(count), 0);
    chk("t6_ovf", int'(overflow), 0);
    // last_grant survives flush: previous winner was wr0, so a tie goes to wr1
    wr0_valid = 1; wr1_valid = 1; wr0_data = 8'h81; wr1_data = 8'h91;
    #1;
    chk("t6_keep_gnt1", int'(wr1_ready), 1);
    chk("t6_keep_gnt0", int'(wr0_ready), 0);
    cyc();
    wr0_valid = 0; wr1_valid = 0;
    pop(8'h91);

    // Reset pulse mid-stream
    push(0, 8'h31); push(0, 8'h32); push(0, 8'h33);
    chk("t6_pre_rst_count", int'(count), 3);
    wr0_valid = 1; wr0_data = 8'h99;
    rst_n = 0;
    #1;
    chk("t6_rst_async_count", int'(count), 0);
    chk("t6_rst_async_empty", int'(empty), 1);
    wr0_valid = 0;
    cyc();
    rst_n = 1;
    #1;
    chk("t6_rst_count", int'(count), 0);
    chk("t6_rst_empty", int'(empty), 1);
    chk("t6_rst_ovf", int'(overflow), 0);
    chk("t6_rst_rdv", int'(rd_valid), 0);
    // last_grant back to reset value: wr0 wins the tie
    wr0_valid = 1; wr1_valid = 1;
    #1;
    chk("t6_rst_gnt0", int'(wr0_ready), 1);
    chk("t6_rst_gnt1", int'(wr1_ready), 0);
    cyc();
    wr0_valid = 0; wr1_valid = 0;
    chk("t6_rst_count1", int'(count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
